regfile_param: RTL and testbench
================================

// Module: regfile_param
// PURPOSE
//  Parametrised integer register file for the pipelined core: NUM_RD combinational read ports, one write port.
//  Self-clears its array after reset via an internal clear sequencer, so no $readmemh init image is needed.
//  Squashes writeback while a timer or external interrupt is being taken, and for one cycle after it.
//  Sits between decode (reads) and writeback (write) stages.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; DEPTH = 2**ADDR_W registers
//  NUM_RD    2   number of independent read ports (>=1)
//  ZERO_REG  1   1: register 0 hardwired to zero; 0: register 0 is an ordinary register
// PORTS
//  clk          in   1               core clock, all state on rising edge
//  reset        in   1               asynchronous, active-high reset
//  rd_addr      in   NUM_RD*ADDR_W   packed read addresses, port p at [p*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   packed read data, port p at [p*DATA_W +: DATA_W]
//  wr_en        in   1               active-high write request
//  wr_addr      in   ADDR_W          write address
//  wr_data      in   DATA_W          write data
//  TimerIntrpt  in   1               timer interrupt being taken
//  intrpt       in   1               external interrupt being taken
//  init_busy    out  1               1 while the clear sequencer is running
//  wr_drop      out  1               registered pulse: the previous cycle's write request was discarded
// BEHAVIOUR
//  - FSM states: CLEAR, RUN. reset asserted -> state=CLEAR, clr_cnt=0, intr_q=0, wr_drop=0, init_busy=1 (async).
//  - CLEAR: each clk writes 0 to reg[clr_cnt] and increments clr_cnt. When clr_cnt==DEPTH-1 the FSM writes that last entry and moves to RUN.
//    init_busy therefore stays 1 for exactly DEPTH cycles after reset deasserts.
//  - reset mid-CLEAR restarts the sequence at 0. The array itself is not async-reset; only the FSM, clr_cnt, intr_q and wr_drop are.
//  - CLEAR: all rd_data = 0. Every wr_en request is discarded; wr_drop=1 the next cycle.
//  - intr_q <= TimerIntrpt | intrpt on every clk.
//  - wr_ok = state==RUN & wr_en & ~TimerIntrpt & ~intrpt & ~intr_q & ~(ZERO_REG & wr_addr==0).
//  - Write: on rising clk when wr_ok, reg[wr_addr] <= wr_data. One write per cycle, no partial writes.
//  - wr_drop <= wr_en & ~wr_ok & ~(ZERO_REG & wr_addr==0). Writes to x0 are silently ignored and are not flagged as drops.
//  - Read: combinational. rd_data[p] = (ZERO_REG & rd_addr[p]==0) ? 0 : reg[rd_addr[p]].
//  - All read ports are independent; any ports may address the same register.
//  - Read and write of the same address in one cycle: see CONFIGURATION.
//  - Interrupt blocking: a write is blocked in any cycle where TimerIntrpt or intrpt is high, and in the cycle immediately after.
//    Back-to-back interrupts extend the blocking window.
//  - No X propagation: wr_en=0 never modifies state, regardless of wr_addr/wr_data.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    When wr_ok and rd_addr[p]==wr_addr (and not hardwired x0), rd_data[p] = wr_data in the same cycle (write-through forwarding).
//  REGFILE_BYPASS_EN undefined:
//    rd_data[p] returns the old contents in that cycle. The new value is visible from the next cycle.
//    The pipeline's hazard unit must cover the one-cycle gap.
// TESTING
//  1. reset 1->0, DEPTH=32:
//     init_busy=1 for 32 cycles then 0. Every register reads 0 afterwards.
//     wr_en during CLEAR -> wr_drop=1 next cycle, value not stored.
//  2. RUN: write x5=0xDEADBEEF, then read port0=x5, port1=x5 next cycle -> both 0xDEADBEEF.
//     Write x0=0x1234 -> x0 reads 0, wr_drop=0.
//  3. Same-cycle write x7=0xA5A5A5A5 with rd_addr0=x7:
//     with REGFILE_BYPASS_EN -> 0xA5A5A5A5 that cycle;
//     without -> old value that cycle, 0xA5A5A5A5 the next cycle.
//  4. Pulse TimerIntrpt for 1 cycle with wr_en held writing x3 = 1, 2, 3 on consecutive cycles:
//     the writes in the pulse cycle and the following cycle are dropped (wr_drop=1 each).
//     The third write lands, so x3=3.
//  5. Assert reset at clr_cnt=10 with x1 previously 0x55: FSM restarts at 0, init_busy stays 1 for a full 32 cycles, x1 reads 0 afterwards.
//  6. NUM_RD=4, ZERO_REG=0: write x0=0x99, all four ports read x0 -> 0x99.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised register file: NUM_RD combinational read ports, one write port, self-clearing after reset.
// Optional write-through forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       TimerIntrpt,
    input  logic                       intrpt,
    output logic                       init_busy,
    output logic                       wr_drop
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};
    localparam bit                HARD_ZERO = (ZERO_REG != 0);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                intr_q;
    logic                wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_to_zero;
    logic                wr_ok;

    assign wr_to_zero = HARD_ZERO && (wr_addr == '0);
    assign wr_ok      = (state_q == RUN) && wr_en && !TimerIntrpt && !intrpt
                        && !intr_q && !wr_to_zero;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        wr_drop_d = wr_en && !wr_ok && !wr_to_zero;
        if (state_q == CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
            intr_q    <= 1'b0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            intr_q    <= TimerIntrpt | intrpt;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage has no reset; the clear sequencer zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;

        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        always_comb begin
            data = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (addr == wr_addr)) begin
                data = wr_data;
            end
`endif
            if ((state_q == CLEAR) || (HARD_ZERO && (addr == '0))) begin
                data = '0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = data;
    end

    assign init_busy = (state_q == CLEAR);
    assign wr_drop   = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench for regfile_param: default build (2 ports, x0 hardwired) plus a 4-port instance without x0.
module tb_regfile_param;

    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [2*AW-1:0]   rd_addr;
    logic [2*DW-1:0]   rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              TimerIntrpt, intrpt;
    logic              init_busy, wr_drop;

    logic [4*AW-1:0]   rd_addr4;
    logic [4*DW-1:0]   rd_data4;
    logic              wr_en4;
    logic [AW-1:0]     wr_addr4;
    logic [DW-1:0]     wr_data4;
    logic              init_busy4, wr_drop4;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_v;

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .TimerIntrpt(TimerIntrpt), .intrpt(intrpt),
        .init_busy(init_busy), .wr_drop(wr_drop)
    );

    regfile_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(0)) dut4 (
        .clk(clk), .reset(reset), .rd_addr(rd_addr4), .rd_data(rd_data4),
        .wr_en(wr_en4), .wr_addr(wr_addr4), .wr_data(wr_data4),
        .TimerIntrpt(1'b0), .intrpt(1'b0),
        .init_busy(init_busy4), .wr_drop(wr_drop4)
    );

    task automatic test_reset();
        int n;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (init_busy !== 1'b1 || wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: busy=%b drop=%b, expected busy=1 drop=0", init_busy, wr_drop);
        end
        rd_addr = {5'd2, 5'd9};
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 3) begin
                exp_q.push_back('0);
                #1;
                exp_v = exp_q.pop_front();
                tests_run++;
                if (rd_data[DW-1:0] !== exp_v) begin
                    tests_failed++;
                    $display("FAIL clear_read: got %h expected %h", rd_data[DW-1:0], exp_v);
                end
            end
            if (n == 5) begin
                wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0077;
            end
            if (n == 6) begin
                wr_en = 1'b0;
                tests_run++;
                if (wr_drop !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL clear_wr_drop: got %b expected 1", wr_drop);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL init_busy_len: got %0d cycles expected 32", n);
        end
        for (int i = 0; i < 32; i++) begin
            rd_addr = {AW'(31 - i), AW'(i)};
            exp_q.push_back('0);
            exp_q.push_back('0);
            #1;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (rd_data[DW-1:0] !== exp_v) begin
                tests_failed++;
                $display("FAIL post_clear_p0 x%0d: got %h expected %h", i, rd_data[DW-1:0], exp_v);
            end
            exp_v = exp_q.pop_front();
            tests_run++;
            if (rd_data[2*DW-1:DW] !== exp_v) begin
                tests_failed++;
                $display("FAIL post_clear_p1 x%0d: got %h expected %h", 31 - i, rd_data[2*DW-1:DW], exp_v);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        wr_en = 1'b0; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        rd_addr = {5'd5, 5'd5};
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL x5_p0: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[2*DW-1:DW] !== exp_v) begin
            tests_failed++;
            $display("FAIL x5_p1: got %h expected %h", rd_data[2*DW-1:DW], exp_v);
        end
        // wr_en low with live address/data must not modify x5
        exp_q.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL wr_en_low: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
        exp_q.push_back('0);
        @(negedge clk);
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd0};
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_drop: got %b expected 0", wr_drop);
        end
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL x0_read: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        rd_addr = {5'd0, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
        exp_q.push_back(32'hA5A5_A5A5);
`else
        exp_q.push_back(32'h0000_0000);
`endif
        exp_q.push_back(32'hA5A5_A5A5);
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL same_cycle_x7: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        @(negedge clk);
        wr_en = 1'b0;
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL next_cycle_x7: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
    endtask

    task automatic test_intr_block();
        // Timer pulse: writes of 1 and 2 dropped, 3 lands
        @(negedge clk);
        rd_addr = {5'd3, 5'd3};
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd1; TimerIntrpt = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            exp_q.push_back('0);
            @(negedge clk);
            TimerIntrpt = 1'b0;
            wr_data = DW'(k + 1);
            tests_run++;
            if (wr_drop !== 1'b1) begin
                tests_failed++;
                $display("FAIL timer_drop%0d: got %b expected 1", k, wr_drop);
            end
            #1;
            exp_v = exp_q.pop_front();
            tests_run++;
            if (rd_data[DW-1:0] !== exp_v) begin
                tests_failed++;
                $display("FAIL timer_hold%0d: got %h expected %h", k, rd_data[DW-1:0], exp_v);
            end
        end
        exp_q.push_back(32'd3);
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL timer_land_drop: got %b expected 0", wr_drop);
        end
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL timer_x3: got %h expected %h", rd_data[DW-1:0], exp_v);
        end

        // Two-cycle external interrupt: three writes dropped, fourth lands
        rd_addr = {5'd4, 5'd4};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                tests_run++;
                if (wr_drop !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ext_drop%0d: got %b expected 1", k, wr_drop);
                end
            end
            wr_en = 1'b1; wr_addr = 5'd4; wr_data = DW'(10 + k);
            intrpt = (k < 2);
        end
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL ext_hold_x4: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        exp_q.push_back(32'd13);
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++;
        if (wr_drop !== 1'b0) begin
            tests_failed++;
            $display("FAIL ext_land_drop: got %b expected 0", wr_drop);
        end
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL ext_x4: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0055;
        @(negedge clk);
        wr_addr = 5'd20; wr_data = 32'h0000_CAFE;
        @(negedge clk);
        wr_en = 1'b0;
        rd_addr = {5'd20, 5'd1};
        exp_q.push_back(32'h0000_0055);
        exp_q.push_back(32'h0000_CAFE);
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL pre_x1: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[2*DW-1:DW] !== exp_v) begin
            tests_failed++;
            $display("FAIL pre_x20: got %h expected %h", rd_data[2*DW-1:DW], exp_v);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        tests_run++;
        if (init_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_reset_busy: got %b expected 1", init_busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        tests_run++;
        if (n != 32) begin
            tests_failed++;
            $display("FAIL restart_len: got %0d cycles expected 32", n);
        end
        exp_q.push_back('0);
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[DW-1:0] !== exp_v) begin
            tests_failed++;
            $display("FAIL post_x1: got %h expected %h", rd_data[DW-1:0], exp_v);
        end
        exp_v = exp_q.pop_front();
        tests_run++;
        if (rd_data[2*DW-1:DW] !== exp_v) begin
            tests_failed++;
            $display("FAIL post_x20: got %h expected %h", rd_data[2*DW-1:DW], exp_v);
        end
    endtask

    task automatic test_no_zero_reg();
        logic [DW-1:0] exp4 [4];
        @(negedge clk);
        tests_run++;
        if (init_busy4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL dut4_busy: got %b expected 0", init_busy4);
        end
        wr_en4 = 1'b1; wr_addr4 = 5'd0; wr_data4 = 32'h0000_0099;
        @(negedge clk);
        wr_addr4 = 5'd31; wr_data4 = 32'h3131_3131;
        tests_run++;
        if (wr_drop4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL dut4_x0_drop: got %b expected 0", wr_drop4);
        end
        @(negedge clk);
        wr_en4 = 1'b0;
        rd_addr4 = '0;
        for (int p = 0; p < 4; p++) exp_q.push_back(32'h0000_0099);
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if (rd_data4[p*DW +: DW] !== exp_v) begin
                tests_failed++;
                $display("FAIL dut4_x0_p%0d: got %h expected %h", p, rd_data4[p*DW +: DW], exp_v);
            end
        end
        rd_addr4 = {5'd0, 5'd31, 5'd0, 5'd31};
        exp4[0] = 32'h3131_3131; exp4[1] = 32'h0000_0099;
        exp4[2] = 32'h3131_3131; exp4[3] = 32'h0000_0099;
        for (int p = 0; p < 4; p++) exp_q.push_back(exp4[p]);
        #1;
        for (int p = 0; p < 4; p++) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if (rd_data4[p*DW +: DW] !== exp_v) begin
                tests_failed++;
                $display("FAIL dut4_mixed_p%0d: got %h expected %h", p, rd_data4[p*DW +: DW], exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        TimerIntrpt = 1'b0; intrpt = 1'b0;
        rd_addr4 = '0; wr_en4 = 1'b0; wr_addr4 = '0; wr_data4 = '0;
        test_reset();
        test_write_read();
        test_same_cycle();
        test_intr_block();
        test_reset_mid_clear();
        test_no_zero_reg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
